// File: rtl/vidin_line_tap_buffer_if.sv
// Pixel-in / vertical-column-out bundle for vidin_line_tap_buffer.
// master drives the raster stream and slave is the tap buffer.
interface vidin_line_tap_buffer_if #(
    parameter int unsigned DW   = 8,
    parameter int unsigned TAPS = 7
);
    logic                 vidin_new_data;
    logic                 vidin_sof;
    logic [DW-1:0]        vidin_in;
    logic [TAPS*DW-1:0]   tap_out;
    logic                 tap_valid;
    logic [7:0]           col_cnt;
    logic [2:0]           row_cnt;
    logic                 line_done;

    modport master (
        output vidin_new_data, vidin_sof, vidin_in,
        input  tap_out, tap_valid, col_cnt, row_cnt, line_done
    );

    modport slave (
        input  vidin_new_data, vidin_sof, vidin_in,
        output tap_out, tap_valid, col_cnt, row_cnt, line_done
    );
endinterface

// File: rtl/vidin_line_tap_buffer.sv
// Line tap buffer: TAPS-1 circular row memories shifted per column on each
// accepted pixel, presenting a registered TAPS-line vertical column.
module vidin_line_tap_buffer #(
    parameter int unsigned H_LEN = 226,
    parameter int unsigned TAPS  = 7,
    parameter int unsigned DW    = 8
) (
    input logic                     tm3_clk_v0,
    input logic                     rst_n,
    vidin_line_tap_buffer_if.slave  bus
);
    localparam int unsigned MEM_ROWS = TAPS - 1;
    localparam int unsigned CW       = (H_LEN > 1) ? $clog2(H_LEN) : 1;
    localparam logic [7:0]  LAST_COL = 8'(H_LEN - 1);
    localparam logic [2:0]  ROW_MAX  = 3'(TAPS - 1);

    logic [TAPS*DW-1:0] tap_out_q, tap_out_d;
    logic               tap_valid_q, tap_valid_d;
    logic [7:0]         col_cnt_q, col_cnt_d;
    logic [2:0]         row_cnt_q, row_cnt_d;
    logic               line_done_q, line_done_d;

    logic               accept;
    logic [CW-1:0]      wr_idx;
    logic [DW-1:0]      rd_data [MEM_ROWS];

    assign accept = bus.vidin_new_data;
    assign wr_idx = bus.vidin_sof ? '0 : col_cnt_q[CW-1:0];

    // Row k holds the line k+1 lines old; each accept reads all rows at the
    // column and writes each with its younger neighbour's old value.
    for (genvar k = 0; k < MEM_ROWS; k++) begin : g_row
        logic [DW-1:0] mem [H_LEN];
        logic [DW-1:0] wr_data;

        if (k == 0) begin : g_first
            assign wr_data = bus.vidin_in;
        end else begin : g_shift
            assign wr_data = rd_data[k-1];
        end

        assign rd_data[k] = mem[wr_idx];

        always_ff @(posedge tm3_clk_v0) begin
            if (rst_n && accept) begin
                mem[wr_idx] <= wr_data;
            end
        end
    end

    always_comb begin
        tap_out_d   = tap_out_q;
        tap_valid_d = 1'b0;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        line_done_d = 1'b0;

        if (accept) begin
            tap_out_d[TAPS*DW-1 -: DW] = bus.vidin_in;
            for (int unsigned k = 0; k < MEM_ROWS; k++) begin
                tap_out_d[(TAPS-2-k)*DW +: DW] = rd_data[k];
            end
            tap_valid_d = !bus.vidin_sof && (row_cnt_q == ROW_MAX);

            // SOF overrides the wrap position: no line_done, no row count.
            if (bus.vidin_sof) begin
                col_cnt_d = 8'd1;
                row_cnt_d = '0;
            end else if (col_cnt_q == LAST_COL) begin
                col_cnt_d   = '0;
                line_done_d = 1'b1;
                row_cnt_d   = (row_cnt_q == ROW_MAX) ? ROW_MAX : row_cnt_q + 3'd1;
            end else begin
                col_cnt_d = col_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge tm3_clk_v0) begin
        if (!rst_n) begin
            tap_out_q   <= '0;
            tap_valid_q <= 1'b0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            line_done_q <= 1'b0;
        end else begin
            tap_out_q   <= tap_out_d;
            tap_valid_q <= tap_valid_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            line_done_q <= line_done_d;
        end
    end

    assign bus.tap_out   = tap_out_q;
    assign bus.tap_valid = tap_valid_q;
    assign bus.col_cnt   = col_cnt_q;
    assign bus.row_cnt   = row_cnt_q;
    assign bus.line_done = line_done_q;
endmodule

// File: tb/tb_vidin_line_tap_buffer.sv
// Self-checking bench for vidin_line_tap_buffer: directed vector table,
// scenario sequences and a per-column history reference model.
module tb_vidin_line_tap_buffer;
    localparam int H  = 226;
    localparam int T  = 7;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vidin_line_tap_buffer_if #(.DW(DW), .TAPS(T)) bus ();

    vidin_line_tap_buffer #(.H_LEN(H), .TAPS(T), .DW(DW)) dut (
        .tm3_clk_v0 (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: per column, the last T-1 pixels accepted there.
    logic [7:0]      hist [H][T-1];
    int              known [H];
    int              m_col, m_row;
    logic            m_valid, m_done;
    logic [T*DW-1:0] m_tap;
    bit              tap_known;
    int              vcnt, dcnt;

    typedef struct {
        bit          rn, nd, sf;
        logic [7:0]  px;
        int          e_col, e_row;
        bit          e_valid, e_done;
        bit          chk_tap;
        logic [55:0] e_tap;
    } vec_t;
    vec_t tbl[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model(bit rn, bit nd, bit sf, logic [7:0] px);
        int c;
        if (!rn) begin
            m_col = 0; m_row = 0; m_tap = '0; m_valid = 0; m_done = 0; tap_known = 1;
        end else if (nd) begin
            c = sf ? 0 : m_col;
            m_tap[T*DW-1 -: DW] = px;
            for (int k = 0; k < T-1; k++) m_tap[(T-2-k)*DW +: DW] = hist[c][k];
            tap_known = (known[c] >= T-1);
            for (int k = T-2; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = px;
            if (known[c] < T-1) known[c]++;
            m_valid = !sf && (m_row == T-1);
            m_done = 0;
            if (sf) begin
                m_col = 1; m_row = 0;
            end else if (c == H-1) begin
                m_col = 0; m_done = 1;
                if (m_row < T-1) m_row++;
            end else begin
                m_col = c + 1;
            end
        end else begin
            m_valid = 0; m_done = 0;
        end
    endtask

    task automatic step(bit rn, bit nd, bit sf, logic [7:0] px);
        rst_n = rn;
        bus.vidin_new_data = nd;
        bus.vidin_sof = sf;
        bus.vidin_in = px;
        @(posedge clk);
        #1;
        model(rn, nd, sf, px);
        check("col_cnt", 64'(bus.col_cnt), 64'(m_col));
        check("row_cnt", 64'(bus.row_cnt), 64'(m_row));
        check("tap_valid", 64'(bus.tap_valid), 64'(m_valid));
        check("line_done", 64'(bus.line_done), 64'(m_done));
        if (tap_known) check("tap_out", 64'(bus.tap_out), 64'(m_tap));
        if (bus.tap_valid === 1'b1) vcnt++;
        if (bus.line_done === 1'b1) dcnt++;
    endtask

    task automatic idle();
        step(1, 0, 0, 8'($urandom));
    endtask

    initial begin
        logic [55:0] exp_tap;
        int bad;
        bus.vidin_new_data = 0; bus.vidin_sof = 0; bus.vidin_in = '0;
        for (int i = 0; i < H; i++) known[i] = 0;
        tap_known = 0;

        // Reset / idle and short SOF sequence as a vector table
        for (int i = 0; i < 3; i++) tbl.push_back('{0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 56'h0});
        for (int i = 0; i < 10; i++) tbl.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 56'h0});
        tbl.push_back('{1, 1, 1, 8'h11, 1, 0, 0, 0, 0, 56'h0});
        tbl.push_back('{1, 1, 0, 8'h22, 2, 0, 0, 0, 0, 56'h0});
        tbl.push_back('{1, 0, 0, 8'h33, 2, 0, 0, 0, 0, 56'h0});
        tbl.push_back('{0, 1, 0, 8'h44, 0, 0, 0, 0, 1, 56'h0});
        tbl.push_back('{1, 1, 0, 8'h55, 1, 0, 0, 0, 0, 56'h0});
        foreach (tbl[i]) begin
            step(tbl[i].rn, tbl[i].nd, tbl[i].sf, tbl[i].px);
            check("tbl_col", 64'(bus.col_cnt), 64'(tbl[i].e_col));
            check("tbl_row", 64'(bus.row_cnt), 64'(tbl[i].e_row));
            check("tbl_valid", 64'(bus.tap_valid), 64'(tbl[i].e_valid));
            check("tbl_done", 64'(bus.line_done), 64'(tbl[i].e_done));
            if (tbl[i].chk_tap) check("tbl_tap", 64'(bus.tap_out), 64'(tbl[i].e_tap));
        end

        // Fill: 7 lines of constant r+1, back to back
        vcnt = 0; dcnt = 0;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < H; c++) begin
                step(1, 1, (r == 0 && c == 0), 8'(r + 1));
                if (r == 6 && c == 0) begin
                    check("first_valid", 64'(bus.tap_valid), 64'd1);
                    check("first_tap", 64'(bus.tap_out), 64'h07_06_05_04_03_02_01);
                    check("valid_before_line6", 64'(vcnt), 64'd1);
                end
            end
        end
        check("fill_valid_cnt", 64'(vcnt), 64'd226);
        check("fill_done_cnt", 64'(dcnt), 64'd7);
        check("fill_row", 64'(bus.row_cnt), 64'd6);

        // Column alignment: pixel = column
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < H; c++) begin
                step(1, 1, (r == 0 && c == 0), 8'(c));
                if (r == 6 && c == H-1) check("align_225", 64'(bus.tap_out), 64'hE1E1E1E1E1E1E1);
            end
        end

        // Gapped input with fill data
        vcnt = 0; bad = 0;
        exp_tap = 56'h07_06_05_04_03_02_01;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < H; c++) begin
                int g;
                g = $urandom_range(0, 5);
                for (int j = 0; j < g; j++) idle();
                step(1, 1, (r == 0 && c == 0), 8'(r + 1));
                if (bus.tap_valid === 1'b1 && bus.tap_out !== exp_tap) bad++;
            end
        end
        check("gap_valid_cnt", 64'(vcnt), 64'd226);
        check("gap_bad_taps", 64'(bad), 64'd0);

        // Mid-frame SOF at col 100 after 8 full lines
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < H; c++) step(1, 1, (r == 0 && c == 0), 8'($urandom));
        for (int c = 0; c < 100; c++) step(1, 1, 0, 8'($urandom));
        dcnt = 0;
        step(1, 1, 1, 8'($urandom));
        check("midsof_col", 64'(bus.col_cnt), 64'd1);
        check("midsof_row", 64'(bus.row_cnt), 64'd0);
        check("midsof_done", 64'(dcnt), 64'd0);
        check("midsof_valid", 64'(bus.tap_valid), 64'd0);
        vcnt = 0;
        for (int c = 1; c < H; c++) step(1, 1, 0, 8'($urandom));
        for (int r = 1; r < 6; r++)
            for (int c = 0; c < H; c++) step(1, 1, 0, 8'($urandom));
        check("midsof_no_early_valid", 64'(vcnt), 64'd0);
        for (int c = 0; c < 20; c++) step(1, 1, 0, 8'($urandom));
        check("midsof_valid_resumes", 64'(vcnt), 64'd20);

        // Reset mid-line at col 50 of line 7, coincident with an accept
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < H; c++) step(1, 1, (r == 0 && c == 0), 8'($urandom));
        for (int c = 0; c < 50; c++) step(1, 1, 0, 8'($urandom));
        step(0, 1, 0, 8'hA5);
        check("rst_tap", 64'(bus.tap_out), 64'd0);
        check("rst_valid", 64'(bus.tap_valid), 64'd0);
        check("rst_col", 64'(bus.col_cnt), 64'd0);
        check("rst_row", 64'(bus.row_cnt), 64'd0);
        check("rst_done", 64'(bus.line_done), 64'd0);
        step(1, 1, 0, 8'h5A);
        check("post_rst_col", 64'(bus.col_cnt), 64'd1);
        check("post_rst_valid", 64'(bus.tap_valid), 64'd0);

        // Random traffic with occasional SOF and reset
        for (int i = 0; i < 3000; i++) begin
            bit rn, nd, sf;
            rn = ($urandom_range(0, 499) != 0);
            nd = ($urandom_range(0, 3) != 0);
            sf = ($urandom_range(0, 299) == 0);
            step(rn, nd, sf, 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vidin_line_tap_buffer.md
Name: vidin_line_tap_buffer

Overview:
Upstream video-input stage feeding the fltr_compute_* vertical filters.
- Accepts one 8-bit pixel per vidin_new_data strobe from a raster stream of H_LEN pixels per line.
- Stores the previous TAPS-1 lines in circular row memories.
- Presents a registered TAPS x 8-bit vertical column (same column, consecutive lines) with a valid strobe, in the exact bit order the filter din bus expects.
- Replaces the free-running fifo226 chain with data-gated, line-length-correct buffering.

Parameters:
- H_LEN, 226: pixels per line; range 2..255.
- TAPS, 7: vertical taps, i.e. lines presented per column; range 2..8.
- DW, 8: pixel width in bits.

Ports:
- tm3_clk_v0  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- vidin_new_data  in  1  pixel accept strobe; one pixel per high cycle; no backpressure.
- vidin_sof  in  1  start of frame; qualified by vidin_new_data; marks the accepted pixel as row 0, col 0.
- vidin_in  in  DW  pixel data.
- tap_out  out  TAPS*DW  vertical column.
  - [TAPS*DW-1 -:DW] is the current line (newest).
  - Each next-lower byte is one line older.
  - [DW-1:0] is TAPS-1 lines ago.
- tap_valid  out  1  one-cycle pulse; tap_out is a complete column.
- col_cnt  out  8  column index of the next pixel to be accepted.
- row_cnt  out  3  lines completed since SOF or reset; saturates at TAPS-1.
- line_done  out  1  one-cycle pulse after the last pixel (col H_LEN-1) of a line is accepted.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - tap_out, tap_valid, col_cnt, row_cnt and line_done all go to 0.
  - Row memory contents are not cleared.
  - Reset mid-line abandons that line; the next accepted pixel is row 0, col 0.
- Accept (vidin_new_data=1):
  - Read column col_cnt from every row memory.
  - Write vidin_in into line-1 memory at col_cnt.
  - Line-k memory receives the old line-(k-1) value at col_cnt (shift through lines).
  - Read-before-write ordering within the same column is mandatory.
- Latency: tap_out and tap_valid update exactly 1 cycle after the accept edge.
  - tap_out holds its value between accepts.
  - tap_valid=0 in every cycle with no preceding accept.
- Column counter:
  - col_cnt increments on each accept.
  - At H_LEN-1 it wraps to 0, line_done pulses in the next cycle, and row_cnt increments (saturating at TAPS-1).
- Validity:
  - tap_valid=1 only for an accept that occurs while row_cnt==TAPS-1.
  - In that case all TAPS bytes hold genuine data from the current frame.
  - Earlier accepts update tap_out, but tap_valid stays 0.
- SOF:
  - vidin_sof=1 with vidin_new_data=1: the pixel is stored at col 0, col_cnt becomes 1, row_cnt becomes 0.
  - That accept produces tap_valid=0.
  - vidin_sof without vidin_new_data is ignored.
  - SOF mid-line truncates the line; partial lines are not counted.
- Simultaneous SOF and wrap position (col_cnt==H_LEN-1 with SOF): SOF wins; no line_done and no row increment.
- Back-to-back accepts on every cycle are supported at full rate with no bubbles.
- Gaps of any length between accepts are tolerated; state is held.
- rst_n=0 coincident with vidin_new_data=1: reset wins and the pixel is dropped.
- Arithmetic: unsigned, no computation on data; pixels pass through bit-exact.
- Storage: (TAPS-1) x H_LEN x DW bits. Single-port read-before-write RAM is acceptable if it meets the 1-cycle latency.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n=0 for 3 cycles, release, no strobes for 10 cycles.
  - Required: all outputs 0 throughout.
- Fill and first valid column (defaults):
  - Stimulus: SOF, then 7 lines of 226 accepts; every pixel of line r (r=0..6) = r+1.
  - Required: line_done pulses 7 times and row_cnt reaches 6.
  - Required: first tap_valid comes 1 cycle after line 6 col 0, with tap_out=56'h07_06_05_04_03_02_01.
  - Required: 226 tap_valid pulses in line 6.
- Column alignment:
  - Stimulus: pixel = col[7:0] on all lines.
  - Required: every valid tap_out has all 7 bytes equal to col, e.g. col 225 gives 56'hE1E1E1E1E1E1E1.
- Gapped input:
  - Stimulus: random 0–5 idle cycles between accepts, same data as the fill scenario.
  - Required: identical tap_out/tap_valid sequence (ignoring timing); no tap_valid without a preceding accept.
- Mid-frame SOF:
  - Stimulus: after 8 full lines, assert SOF at col 100.
  - Required: col_cnt=1 and row_cnt=0 after that accept; no line_done; tap_valid stays 0 until row_cnt returns to 6.
- Reset mid-line:
  - Stimulus: rst_n=0 for 1 cycle at col 50 of line 7 with vidin_new_data=1.
  - Required: that pixel is dropped; all outputs are 0 the next cycle; the next accept is col 0 and gives tap_valid=0.
